// File: rtl/mmv_ofm_packer.sv
// mmv_ofm_packer: regroups a fold-serial output-pixel stream into MMV_OUT-pixel-wide beats.
// A ping-pong pair of banks lets one group fill while the previous group drains.
module mmv_ofm_packer #(
    parameter int PE          = 1,
    parameter int PRECISION   = 8,
    parameter int OFMChannels = 4,
    parameter int OFMWidth    = 5,
    parameter int OFMHeight   = 2,
    parameter int MMV_OUT     = 2,
    parameter     RAM_STYLE   = "auto"
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic [PE*PRECISION-1:0]         s_axis_tdata,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    output logic [MMV_OUT*PE*PRECISION-1:0] m_axis_tdata,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tlast
);

    localparam int NF   = OFMChannels / PE;
    localparam int DW   = PE * PRECISION;
    localparam int OW   = MMV_OUT * DW;
    localparam int FW   = $clog2(NF > 2 ? NF : 2);
    localparam int LW   = $clog2(MMV_OUT > 2 ? MMV_OUT : 2);
    localparam int CW   = $clog2(OFMWidth > 2 ? OFMWidth : 2);
    localparam int RW   = $clog2(OFMHeight > 2 ? OFMHeight : 2);
    localparam int CNTW = $clog2(MMV_OUT + 1);

    localparam logic [FW-1:0] FOLD_MAX = FW'(NF - 1);
    localparam logic [LW-1:0] LANE_MAX = LW'(MMV_OUT - 1);
    localparam logic [CW-1:0] COL_MAX  = CW'(OFMWidth - 1);
    localparam logic [RW-1:0] ROW_MAX  = RW'(OFMHeight - 1);

    (* ram_style = RAM_STYLE *)
    logic [DW-1:0] mem_q [2][MMV_OUT][NF];

    logic                       aresetn_q;
    logic [FW-1:0]              fold_q, fold_d;
    logic [LW-1:0]              lane_q, lane_d;
    logic [CW-1:0]              col_q, col_d;
    logic [RW-1:0]              row_q, row_d;
    logic                       wb_q, wb_d;
    logic                       rb_q, rb_d;
    logic [FW-1:0]              rf_q, rf_d;
    logic [1:0]                 full_q, full_d;
    logic [1:0][CNTW-1:0]       cnt_q, cnt_d;
    logic [1:0]                 last_grp_q, last_grp_d;

    logic                       rd_valid_q, rd_valid_d;
    logic [OW-1:0]              rd_data_q, rd_data_d;
    logic                       rd_last_q, rd_last_d;
    logic                       out_valid_q, out_valid_d;
    logic [OW-1:0]              out_data_q, out_data_d;
    logic                       out_last_q, out_last_d;

    logic                       in_fire;
    logic                       fold_end;
    logic                       lane_end;
    logic                       row_tail;
    logic                       row_end;
    logic                       rd_adv;
    logic                       rd_issue;
    logic                       rd_last_fold;
    logic                       m_fire;
    logic [OW-1:0]              rd_beat;

    assign s_axis_tready = aresetn_q & ~full_q[wb_q];
    assign in_fire       = s_axis_tvalid & s_axis_tready;
    assign fold_end      = (fold_q == FOLD_MAX);
    assign lane_end      = (lane_q == LANE_MAX);
    assign row_tail      = (col_q == COL_MAX);
    assign row_end       = (row_q == ROW_MAX);

    assign m_fire        = out_valid_q & m_axis_tready;
    assign rd_adv        = rd_valid_q & (~out_valid_q | m_axis_tready);
    // A bank is released as soon as its last fold moves into the read register,
    // so the writer can refill it while that fold is still in the output pipe.
    assign rd_issue      = full_q[rb_q] & (~rd_valid_q | rd_adv);
    assign rd_last_fold  = (rf_q == FOLD_MAX);

    assign m_axis_tdata  = out_data_q;
    assign m_axis_tvalid = out_valid_q;
    assign m_axis_tlast  = out_last_q;

    always_comb begin
        rd_beat = '0;
        for (int k = 0; k < MMV_OUT; k++) begin
            if (CNTW'(k) < cnt_q[rb_q]) begin
                rd_beat[k*DW +: DW] = mem_q[rb_q][k][rf_q];
            end
        end
    end

    always_comb begin
        fold_d     = fold_q;
        lane_d     = lane_q;
        col_d      = col_q;
        row_d      = row_q;
        wb_d       = wb_q;
        rb_d       = rb_q;
        rf_d       = rf_q;
        full_d     = full_q;
        cnt_d      = cnt_q;
        last_grp_d = last_grp_q;

        if (rd_issue) begin
            if (rd_last_fold) begin
                full_d[rb_q] = 1'b0;
                rb_d         = ~rb_q;
                rf_d         = '0;
            end else begin
                rf_d = rf_q + FW'(1);
            end
        end

        if (in_fire) begin
            if (!fold_end) begin
                fold_d = fold_q + FW'(1);
            end else begin
                fold_d = '0;
                if (row_tail) begin
                    col_d = '0;
                    row_d = row_end ? '0 : row_q + RW'(1);
                end else begin
                    col_d = col_q + CW'(1);
                end
                // A short group at the row tail closes early with fewer lanes.
                if (lane_end || row_tail) begin
                    full_d[wb_q]     = 1'b1;
                    cnt_d[wb_q]      = CNTW'(lane_q) + CNTW'(1);
                    last_grp_d[wb_q] = row_end & row_tail;
                    wb_d             = ~wb_q;
                    lane_d           = '0;
                end else begin
                    lane_d = lane_q + LW'(1);
                end
            end
        end
    end

    always_comb begin
        rd_valid_d  = rd_valid_q;
        rd_data_d   = rd_data_q;
        rd_last_d   = rd_last_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;

        if (rd_issue) begin
            rd_valid_d = 1'b1;
            rd_data_d  = rd_beat;
            rd_last_d  = last_grp_q[rb_q] & rd_last_fold;
        end else if (rd_adv) begin
            rd_valid_d = 1'b0;
        end

        if (rd_adv) begin
            out_valid_d = 1'b1;
            out_data_d  = rd_data_q;
            out_last_d  = rd_last_q;
        end else if (m_fire) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (aresetn && in_fire) begin
            mem_q[wb_q][lane_q][fold_q] <= s_axis_tdata;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            aresetn_q   <= 1'b0;
            fold_q      <= '0;
            lane_q      <= '0;
            col_q       <= '0;
            row_q       <= '0;
            wb_q        <= 1'b0;
            rb_q        <= 1'b0;
            rf_q        <= '0;
            full_q      <= '0;
            cnt_q       <= '0;
            last_grp_q  <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            rd_last_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            aresetn_q   <= 1'b1;
            fold_q      <= fold_d;
            lane_q      <= lane_d;
            col_q       <= col_d;
            row_q       <= row_d;
            wb_q        <= wb_d;
            rb_q        <= rb_d;
            rf_q        <= rf_d;
            full_q      <= full_d;
            cnt_q       <= cnt_d;
            last_grp_q  <= last_grp_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            rd_last_q   <= rd_last_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

endmodule

// File: tb/tb_mmv_ofm_packer.sv
// Scoreboard bench for mmv_ofm_packer: directed frames with a pixel-level expectation queue
// and an independent output monitor.
module tb_mmv_ofm_packer;

    localparam int PE   = 2;
    localparam int PREC = 8;
    localparam int OFMC = 4;
    localparam int W    = 5;
    localparam int H    = 2;
    localparam int MMV  = 2;
    localparam int NF   = OFMC / PE;
    localparam int DW   = PE * PREC;
    localparam int OW   = MMV * DW;

    typedef struct packed {
        logic [OW-1:0] data;
        logic          last;
    } beat_t;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [DW-1:0] s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic [OW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready = 1'b1;
    logic          m_tlast;

    beat_t exp_q[$];
    beat_t cap_q[$];
    int    total = 0;
    int    bad = 0;
    int    closed_grp = 0;
    int    delivered_grp = 0;
    int    deliv_fold = 0;
    int    in_stalls = 0;
    bit    bp_mode = 1'b0;
    bit    stall_pending = 1'b0;
    beat_t held;

    mmv_ofm_packer #(
        .PE(PE), .PRECISION(PREC), .OFMChannels(OFMC), .OFMWidth(W),
        .OFMHeight(H), .MMV_OUT(MMV), .RAM_STYLE("auto")
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .s_axis_tdata(s_tdata),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready),
        .m_axis_tlast(m_tlast)
    );

    always #5 aclk = ~aclk;

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Reference model: pixels of a row are grouped MMV at a time, short groups zero-padded.
    task automatic pushFrame();
        beat_t b;
        int    p;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c += MMV) begin
                for (int f = 0; f < NF; f++) begin
                    b.data = '0;
                    for (int k = 0; k < MMV; k++) begin
                        if (c + k < W) begin
                            p = r * W + c + k;
                            b.data[k*DW +: DW] = {p[7:0], 8'(f)};
                        end
                    end
                    b.last = (r == H - 1) && (c + MMV >= W) && (f == NF - 1);
                    exp_q.push_back(b);
                end
            end
        end
    endtask

    task automatic applyStimulus(input int p, input int f);
        int waited;
        int c;
        c = p % W;
        @(negedge aclk);
        s_tdata  = {8'(p), 8'(f)};
        s_tvalid = 1'b1;
        waited   = 0;
        while (!s_tready) begin
            if (bp_mode) checkOutput("tready_drop_both_full", 64'(closed_grp - delivered_grp >= 2), 64'd1);
            in_stalls++;
            waited++;
            if (waited > 300) begin
                total++;
                bad++;
                $display("[TB] FAIL input_timeout: got tready=0 want tready=1 for pixel %0d", p);
                s_tvalid = 1'b0;
                return;
            end
            @(negedge aclk);
        end
        @(posedge aclk);
        if (f == NF - 1 && ((c % MMV) == MMV - 1 || c == W - 1)) closed_grp++;
    endtask

    task automatic sendRange(input int p0, input int p1);
        for (int p = p0; p <= p1; p++)
            for (int f = 0; f < NF; f++)
                applyStimulus(p, f);
    endtask

    task automatic idleInput();
        @(negedge aclk);
        s_tvalid = 1'b0;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(negedge aclk);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain_timeout: got %0d beats outstanding want 0", exp_q.size());
        end
        repeat (3) @(negedge aclk);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_tvalid"}, 64'(m_tvalid), 64'd0);
        checkOutput({tag, "_tdata"},  64'(m_tdata),  64'd0);
        checkOutput({tag, "_tlast"},  64'(m_tlast),  64'd0);
        checkOutput({tag, "_tready"}, 64'(s_tready), 64'd0);
    endtask

    // Output monitor: sampled on the falling edge, pops on every beat that will be accepted.
    always @(negedge aclk) begin
        beat_t e;
        if (aresetn) begin
            if (stall_pending)
                checkOutput("stall_hold", {30'd0, m_tvalid, m_tdata, m_tlast}, {30'd0, 1'b1, held});
            if (m_tvalid) begin
                if (m_tready) begin
                    stall_pending = 1'b0;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("[TB] FAIL unexpected_beat: got %0h want no beat", m_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("beat", {31'd0, m_tdata, m_tlast}, {31'd0, e});
                    end
                    cap_q.push_back({m_tdata, m_tlast});
                    deliv_fold++;
                    if (deliv_fold == NF) begin
                        deliv_fold = 0;
                        delivered_grp++;
                    end
                end else begin
                    held = {m_tdata, m_tlast};
                    stall_pending = 1'b1;
                end
            end else begin
                stall_pending = 1'b0;
            end
        end
    end

    initial begin
        bit [3:0] pat;
        int       idx;
        pat = 4'b1001;
        idx = 0;
        forever begin
            @(posedge aclk);
            #1;
            if (bp_mode) begin
                m_tready = pat[idx];
                idx = (idx + 1) % 4;
            end
        end
    end

    initial begin
        logic [4:0] vld;

        repeat (3) @(negedge aclk);
        checkResetOutputs("reset");
        aresetn = 1'b1;
        @(negedge aclk);
        checkOutput("tready_after_reset", 64'(s_tready), 64'd1);

        $display("[TB] basic packing and latency");
        pushFrame();
        sendRange(0, 1);
        @(negedge aclk);
        s_tvalid = 1'b0;
        vld[0] = m_tvalid;
        for (int i = 1; i < 5; i++) begin
            @(negedge aclk);
            vld[i] = m_tvalid;
        end
        checkOutput("latency_valid_profile", 64'(vld), 64'(5'b01100));
        sendRange(2, 9);
        idleInput();
        waitDrain();
        checkOutput("basic_count", 64'(cap_q.size()), 64'd12);
        if (cap_q.size() >= 12) begin
            checkOutput("pix01_fold1", 64'(cap_q[1].data),  64'h0101_0001);
            checkOutput("pix4_pad",    64'(cap_q[5].data),  64'h0000_0401);
            checkOutput("pix56_fold0", 64'(cap_q[6].data),  64'h0600_0500);
            checkOutput("last_b11",    64'(cap_q[10].last), 64'd0);
            checkOutput("last_b12",    64'(cap_q[11].last), 64'd1);
        end

        $display("[TB] backpressure");
        cap_q.delete();
        pushFrame();
        bp_mode = 1'b1;
        sendRange(0, 9);
        idleInput();
        waitDrain();
        bp_mode = 1'b0;
        @(negedge aclk);
        m_tready = 1'b1;
        checkOutput("bp_count", 64'(cap_q.size()), 64'd12);

        $display("[TB] back-to-back frames");
        cap_q.delete();
        pushFrame();
        pushFrame();
        in_stalls = 0;
        sendRange(0, 9);
        sendRange(0, 9);
        idleInput();
        waitDrain();
        checkOutput("b2b_count", 64'(cap_q.size()), 64'd24);
        checkOutput("b2b_input_stalls", 64'(in_stalls), 64'd0);
        if (cap_q.size() >= 24) begin
            checkOutput("b2b_last12", 64'(cap_q[11].last), 64'd1);
            checkOutput("b2b_last24", 64'(cap_q[23].last), 64'd1);
            checkOutput("b2b_f2_pix01", 64'(cap_q[13].data), 64'h0101_0001);
        end

        $display("[TB] reset mid-group");
        applyStimulus(0, 0);
        applyStimulus(0, 1);
        applyStimulus(1, 0);
        @(negedge aclk);
        aresetn  = 1'b0;
        s_tvalid = 1'b0;
        @(negedge aclk);
        checkResetOutputs("midreset");
        exp_q.delete();
        closed_grp = 0;
        delivered_grp = 0;
        deliv_fold = 0;
        stall_pending = 1'b0;
        aresetn = 1'b1;
        cap_q.delete();
        pushFrame();
        sendRange(0, 9);
        idleInput();
        waitDrain();
        checkOutput("post_reset_count", 64'(cap_q.size()), 64'd12);
        if (cap_q.size() >= 12)
            checkOutput("post_reset_pix01", 64'(cap_q[1].data), 64'h0101_0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got running want finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
